// File: rtl/bsg_make_2d_array_serial.sv
// bsg_make_2d_array_serial
// Unpacks one flattened word of items_p elements (width_p bits each) into a
// stream of single elements, element 0 first. The input side is valid/ready;
// the output side is valid/yumi. A new word may be accepted in the same cycle
// that the last element of the current word is consumed, so a continuous
// supply of words produces a continuous element stream with no bubble.

module bsg_make_2d_array_serial #(
  parameter  int width_p     = 32,
  parameter  int items_p     = 5,
  localparam int lg_items_lp = (items_p > 1) ? $clog2(items_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic                       v_i,
  input  logic [items_p*width_p-1:0] data_i,
  output logic                       ready_o,

  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [lg_items_lp-1:0]     idx_o,
  output logic                       last_o,
  input  logic                       yumi_i
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [lg_items_lp-1:0] LastIdx = lg_items_lp'(items_p - 1);

  state_t                            r_state;
  logic [items_p-1:0][width_p-1:0]   r_data;
  logic [lg_items_lp-1:0]            r_idx;

  state_t                            w_stateNext;
  logic [lg_items_lp-1:0]            w_idxNext;
  logic                              w_load;
  logic                              w_send;
  logic                              w_last;
  logic                              w_ready;

  // State, index and stored word; reset discards any partially sent word.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      if (w_load) begin
        r_data <= data_i;
      end
    end
  end

  // Next-state, index advance and handshake decode.
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_load      = 1'b0;
    w_send      = (r_state == SEND);
    w_last      = w_send && (r_idx == LastIdx);
    w_ready     = !w_send || (w_last && yumi_i);

    case (r_state)
      IDLE: begin
        if (v_i) begin
          w_stateNext = SEND;
          w_idxNext   = '0;
          w_load      = 1'b1;
        end
      end
      SEND: begin
        if (yumi_i) begin
          if (!w_last) begin
            w_idxNext = r_idx + lg_items_lp'(1);
          end else begin
            w_idxNext = '0;
            if (v_i) begin
              w_load = 1'b1;
            end else begin
              w_stateNext = IDLE;
            end
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_idxNext   = '0;
      end
    endcase
  end

  assign ready_o = w_ready;
  assign v_o     = w_send;
  assign data_o  = w_send ? r_data[r_idx] : '0;
  assign idx_o   = r_idx;
  assign last_o  = w_last;

endmodule

// File: tb/tb_bsg_make_2d_array_serial.sv
// tb_bsg_make_2d_array_serial
// Directed bench for the word-to-element serializer. One instance uses the
// default 5 x 32-bit geometry, a second uses a single 8-bit element per word.

module tb_bsg_make_2d_array_serial;

  localparam logic [159:0] WordA    = 160'h00000005_00000004_00000003_00000002_00000001;
  localparam logic [159:0] WordB    = 160'h0000000E_0000000D_0000000C_0000000B_0000000A;
  localparam logic [159:0] WordC    = 160'h00000025_00000024_00000023_00000022_00000021;
  localparam logic [159:0] WordD    = 160'h00000035_00000034_00000033_00000032_00000031;
  localparam logic [159:0] WordJunk = 160'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  logic         clk;
  logic         resetN;

  logic         vIn;
  logic [159:0] dataIn;
  logic         yumiEn;
  logic         yumi;
  logic         readyOut;
  logic         vOut;
  logic [31:0]  dataOut;
  logic [2:0]   idxOut;
  logic         lastOut;

  logic         vIn1;
  logic [7:0]   dataIn1;
  logic         yumiEn1;
  logic         yumi1;
  logic         readyOut1;
  logic         vOut1;
  logic [7:0]   dataOut1;
  logic [0:0]   idxOut1;
  logic         lastOut1;

  int errors = 0;
  int checks = 0;

  // The consumer only takes an element when one is offered.
  assign yumi  = yumiEn & vOut;
  assign yumi1 = yumiEn1 & vOut1;

  bsg_make_2d_array_serial #(.width_p(32), .items_p(5)) dut (
    .clk_i     (clk),
    .reset_n_i (resetN),
    .v_i       (vIn),
    .data_i    (dataIn),
    .ready_o   (readyOut),
    .v_o       (vOut),
    .data_o    (dataOut),
    .idx_o     (idxOut),
    .last_o    (lastOut),
    .yumi_i    (yumi)
  );

  bsg_make_2d_array_serial #(.width_p(8), .items_p(1)) dut1 (
    .clk_i     (clk),
    .reset_n_i (resetN),
    .v_i       (vIn1),
    .data_i    (dataIn1),
    .ready_o   (readyOut1),
    .v_o       (vOut1),
    .data_o    (dataOut1),
    .idx_o     (idxOut1),
    .last_o    (lastOut1),
    .yumi_i    (yumi1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the 5-element instance's inputs.
  task automatic applyStimulus(input logic v, input logic [159:0] d, input logic y);
    vIn    = v;
    dataIn = d;
    yumiEn = y;
  endtask

  // Compare the 5-element instance's outputs, letting combinational paths settle first.
  task automatic checkOutput(input string tag, input logic expV, input logic [31:0] expData,
                             input logic [2:0] expIdx, input logic expLast, input logic expReady);
    #1;
    checks++;
    assert (vOut === expV) else begin
      errors++;
      $error("FAIL %s v_o got=%0b want=%0b", tag, vOut, expV);
    end
    checks++;
    assert (idxOut === expIdx) else begin
      errors++;
      $error("FAIL %s idx_o got=%0d want=%0d", tag, idxOut, expIdx);
    end
    checks++;
    assert (lastOut === expLast) else begin
      errors++;
      $error("FAIL %s last_o got=%0b want=%0b", tag, lastOut, expLast);
    end
    checks++;
    assert (readyOut === expReady) else begin
      errors++;
      $error("FAIL %s ready_o got=%0b want=%0b", tag, readyOut, expReady);
    end
    if (expV) begin
      checks++;
      assert (dataOut === expData) else begin
        errors++;
        $error("FAIL %s data_o got=%h want=%h", tag, dataOut, expData);
      end
    end
  endtask

  // Compare the single-element instance's outputs.
  task automatic checkOutput1(input string tag, input logic expV, input logic [7:0] expData,
                              input logic expIdx, input logic expLast, input logic expReady);
    #1;
    checks++;
    assert (vOut1 === expV) else begin
      errors++;
      $error("FAIL %s v_o got=%0b want=%0b", tag, vOut1, expV);
    end
    checks++;
    assert (idxOut1 === expIdx) else begin
      errors++;
      $error("FAIL %s idx_o got=%0d want=%0d", tag, idxOut1, expIdx);
    end
    checks++;
    assert (lastOut1 === expLast) else begin
      errors++;
      $error("FAIL %s last_o got=%0b want=%0b", tag, lastOut1, expLast);
    end
    checks++;
    assert (readyOut1 === expReady) else begin
      errors++;
      $error("FAIL %s ready_o got=%0b want=%0b", tag, readyOut1, expReady);
    end
    if (expV) begin
      checks++;
      assert (dataOut1 === expData) else begin
        errors++;
        $error("FAIL %s data_o got=%h want=%h", tag, dataOut1, expData);
      end
    end
  endtask

  // Directed sequence: reset, single word, stall, back-to-back, ignored input,
  // mid-word reset, then the single-element geometry.
  initial begin
    resetN = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    vIn1    = 1'b0;
    dataIn1 = '0;
    yumiEn1 = 1'b0;

    #2;
    checkOutput("reset", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    checkOutput1("reset1", 1'b0, 8'h0, 1'b0, 1'b0, 1'b1);
    #9;
    resetN = 1'b1;
    tick();

    // Single word, consumer always ready.
    applyStimulus(1'b1, WordA, 1'b1);
    checkOutput("t1 idle", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, WordA, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t1 e%0d", k), 1'b1, 32'(k + 1), 3'(k), (k == 4), (k == 4));
      tick();
    end
    checkOutput("t1 done", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);

    // Consumer stalls for three cycles on element 2.
    applyStimulus(1'b1, WordA, 1'b1);
    tick();
    applyStimulus(1'b0, WordA, 1'b1);
    checkOutput("t2 e0", 1'b1, 32'd1, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("t2 e1", 1'b1, 32'd2, 3'd1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, WordA, 1'b0);
    for (int s = 0; s < 3; s++) begin
      checkOutput($sformatf("t2 stall%0d", s), 1'b1, 32'd3, 3'd2, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, WordA, 1'b1);
    checkOutput("t2 resume", 1'b1, 32'd3, 3'd2, 1'b0, 1'b0);
    tick();
    checkOutput("t2 e3", 1'b1, 32'd4, 3'd3, 1'b0, 1'b0);
    tick();
    checkOutput("t2 e4", 1'b1, 32'd5, 3'd4, 1'b1, 1'b1);
    tick();
    checkOutput("t2 done", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);

    // Back-to-back words with v_i held high.
    applyStimulus(1'b1, WordA, 1'b1);
    tick();
    applyStimulus(1'b1, WordB, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t3 A%0d", k), 1'b1, 32'(k + 1), 3'(k), (k == 4), (k == 4));
      tick();
    end
    applyStimulus(1'b0, WordB, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t3 B%0d", k), 1'b1, 32'(k + 10), 3'(k), (k == 4), (k == 4));
      tick();
    end
    checkOutput("t3 done", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);

    // Input changes while busy must not disturb the word in flight.
    applyStimulus(1'b1, WordC, 1'b1);
    tick();
    applyStimulus(1'b1, WordJunk, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t6 C%0d", k), 1'b1, 32'(k + 33), 3'(k), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, WordJunk, 1'b1);
    checkOutput("t6 C4", 1'b1, 32'h25, 3'd4, 1'b1, 1'b1);
    tick();
    checkOutput("t6 done", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);

    // Asynchronous reset while element 3 is on the output.
    applyStimulus(1'b1, WordA, 1'b1);
    tick();
    applyStimulus(1'b0, WordA, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
    end
    checkOutput("t4 pre", 1'b1, 32'd4, 3'd3, 1'b0, 1'b0);
    #1;
    resetN = 1'b0;
    checkOutput("t4 in reset", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    #2;
    resetN = 1'b1;
    checkOutput("t4 released", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, WordD, 1'b1);
    checkOutput("t4 idle", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, WordD, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t4 D%0d", k), 1'b1, 32'(k + 49), 3'(k), (k == 4), (k == 4));
      tick();
    end
    checkOutput("t4 done", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);

    // Single-element words: every element is last, reloads without a bubble.
    vIn1    = 1'b1;
    dataIn1 = 8'h11;
    yumiEn1 = 1'b1;
    checkOutput1("t5 idle", 1'b0, 8'h0, 1'b0, 1'b0, 1'b1);
    tick();
    dataIn1 = 8'h22;
    checkOutput1("t5 w11", 1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
    tick();
    dataIn1 = 8'h33;
    checkOutput1("t5 w22", 1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
    tick();
    vIn1 = 1'b0;
    checkOutput1("t5 w33", 1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput1("t5 done", 1'b0, 8'h0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
